// File: rtl/spi_block_sequencer_if.sv
// Block/byte handshake bundle between the AES datapath, the block sequencer and the SPI byte engine.
// master = sequencer view, slave = surrounding datapath/engine view.
interface spi_block_sequencer_if #(
  parameter int unsigned NBYTES = 16
) ();
  logic                  blk_valid;
  logic                  blk_ready;
  logic [8*NBYTES-1:0]   blk_tx;
  logic [8*NBYTES-1:0]   blk_rx;
  logic                  blk_rx_valid;
  logic                  byte_start;
  logic [7:0]            byte_tx;
  logic [7:0]            byte_rx;
  logic                  byte_done;
  logic                  cs_n;
  logic                  busy;

  modport master (
    input  blk_valid, blk_tx, byte_rx, byte_done,
    output blk_ready, blk_rx, blk_rx_valid, byte_start, byte_tx, cs_n, busy
  );

  modport slave (
    output blk_valid, blk_tx, byte_rx, byte_done,
    input  blk_ready, blk_rx, blk_rx_valid, byte_start, byte_tx, cs_n, busy
  );
endinterface

// File: rtl/spi_block_sequencer.sv
// Moves one NBYTES block through the 8-bit SPI byte engine, MSB byte first, cs_n held low per block.
// Optional feature macro: SPI_SEQ_TIMEOUT_EN adds a byte_done watchdog and the sticky timeout_err port.
module spi_block_sequencer #(
  parameter int unsigned NBYTES     = 16,
  parameter int unsigned CS_SETUP   = 2,
  parameter int unsigned GAP_CYCLES = 1
`ifdef SPI_SEQ_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  spi_block_sequencer_if.master  bus
`ifdef SPI_SEQ_TIMEOUT_EN
  , output logic                 timeout_err
`endif
);

  localparam int unsigned DW       = 8 * NBYTES;
  localparam int unsigned CNT_W    = $clog2(NBYTES + 1);
  localparam int unsigned BASE_MAX = (CS_SETUP > GAP_CYCLES) ? CS_SETUP : GAP_CYCLES;
`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int unsigned TMR_MAX  = (TIMEOUT_CYCLES > BASE_MAX) ? TIMEOUT_CYCLES : BASE_MAX;
`else
  localparam int unsigned TMR_MAX  = BASE_MAX;
`endif
  localparam int unsigned TMR_W    = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_START, S_WAIT, S_GAP, S_HOLD
  } state_t;

  state_t           state;
  logic [DW-1:0]    tx_sh;
  logic [DW-1:0]    rx_sh;
  logic [CNT_W-1:0] cnt;
  logic [TMR_W-1:0] tmr;

  logic [DW-1:0]    tx_next;
  logic [DW-1:0]    rx_next;
  logic [CNT_W-1:0] cnt_next;

  // Shift/count values committed when the engine reports a finished byte.
  always_comb begin
    tx_next  = tx_sh << 8;
    rx_next  = (rx_sh << 8) | DW'(bus.byte_rx);
    cnt_next = cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      tx_sh            <= '0;
      rx_sh            <= '0;
      cnt              <= '0;
      tmr              <= '0;
      bus.blk_ready    <= 1'b1;
      bus.cs_n         <= 1'b1;
      bus.byte_start   <= 1'b0;
      bus.byte_tx      <= '0;
      bus.blk_rx       <= '0;
      bus.blk_rx_valid <= 1'b0;
      bus.busy         <= 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
      timeout_err      <= 1'b0;
`endif
    end else begin
      bus.byte_start   <= 1'b0;
      bus.blk_rx_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.blk_valid && bus.blk_ready) begin
            tx_sh         <= bus.blk_tx;
            rx_sh         <= '0;
            cnt           <= '0;
            tmr           <= '0;
            bus.cs_n      <= 1'b0;
            bus.blk_ready <= 1'b0;
            bus.busy      <= 1'b1;
            state         <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (tmr == TMR_W'(CS_SETUP - 1)) begin
            tmr            <= '0;
            bus.byte_start <= 1'b1;
            bus.byte_tx    <= tx_sh[DW-1 -: 8];
            state          <= S_START;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        S_START: begin
          tmr   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.byte_done) begin
            tx_sh <= tx_next;
            rx_sh <= rx_next;
            cnt   <= cnt_next;
            tmr   <= '0;
            // Last byte: publish the block in the same edge that releases chip-select.
            if (cnt_next == CNT_W'(NBYTES)) begin
              bus.cs_n         <= 1'b1;
              bus.blk_rx       <= rx_next;
              bus.blk_rx_valid <= 1'b1;
              state            <= S_HOLD;
            end else if (GAP_CYCLES == 0) begin
              bus.byte_start <= 1'b1;
              bus.byte_tx    <= tx_next[DW-1 -: 8];
              state          <= S_START;
            end else begin
              state <= S_GAP;
            end
          end
`ifdef SPI_SEQ_TIMEOUT_EN
          else if (tmr == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_err   <= 1'b1;
            bus.cs_n      <= 1'b1;
            bus.busy      <= 1'b0;
            bus.blk_ready <= 1'b1;
            state         <= S_IDLE;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
`endif
        end
        S_GAP: begin
          if (tmr == TMR_W'(GAP_CYCLES - 1)) begin
            tmr            <= '0;
            bus.byte_start <= 1'b1;
            bus.byte_tx    <= tx_sh[DW-1 -: 8];
            state          <= S_START;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        S_HOLD: begin
          bus.blk_ready <= 1'b1;
          bus.busy      <= 1'b0;
          state         <= S_IDLE;
        end
        default: begin
          bus.cs_n      <= 1'b1;
          bus.blk_ready <= 1'b1;
          bus.busy      <= 1'b0;
          state         <= S_IDLE;
        end
      endcase
    end
  end

endmodule
